// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results are computed from issue-time operands and committed on the edge busy falls.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  E_MDop,
   input  logic [31:0] E_rsValue,
   input  logic [31:0] E_rtValue,
   input  logic        E_MFsel,
   output logic        E_MDbusy,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO,
   output logic [31:0] E_MDout
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi, lo;
   logic        busy;

   logic        is_signed, a_neg, b_neg;
   logic [31:0] abs_a, abs_b, q_u, r_u, quot, rem;
   logic [63:0] ext_a, ext_b, prod;

   // One multiplier and one unsigned divider serve both signednesses:
   // signed division runs on magnitudes and the signs are restored afterwards.
   always_comb begin
      is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
      a_neg     = is_signed && a_q[31];
      b_neg     = is_signed && b_q[31];
      ext_a     = {{32{a_neg}}, a_q};
      ext_b     = {{32{b_neg}}, b_q};
      prod      = ext_a * ext_b;
      abs_a     = a_neg ? -a_q : a_q;
      abs_b     = b_neg ? -b_q : b_q;
      q_u       = '0;
      r_u       = '0;
      if (abs_b != '0) begin
         q_u = abs_a / abs_b;
         r_u = abs_a % abs_b;
      end
      quot      = (a_neg ^ b_neg) ? -q_u : q_u;
      rem       = a_neg ? -r_u : r_u;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (E_MDop >= OP_MULT && E_MDop <= OP_DIVU) begin
                  op_q  <= E_MDop;
                  a_q   <= E_rsValue;
                  b_q   <= E_rtValue;
                  cnt   <= (E_MDop <= OP_MULTU) ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
                  state <= RUN;
                  busy  <= 1'b1;
               end else if (E_MDop == OP_MTHI) begin
                  hi <= E_rsValue;
               end else if (E_MDop == OP_MTLO) begin
                  lo <= E_rsValue;
               end
            end
            RUN: begin
               // New ops are dropped here; the hazard unit is expected to stall on busy.
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (op_q == OP_MULT || op_q == OP_MULTU) begin
                     hi <= prod[63:32];
                     lo <= prod[31:0];
                  end else if (b_q != '0) begin
                     hi <= rem;
                     lo <= quot;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign E_MDbusy = busy;
   assign E_HI     = hi;
   assign E_LO     = lo;
   assign E_MDout  = E_MFsel ? lo : hi;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO queued at issue, compared when busy falls.
module tb_e_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  E_MDop;
   logic [31:0] E_rsValue, E_rtValue;
   logic        E_MFsel;
   logic        E_MDbusy;
   logic [31:0] E_HI, E_LO, E_MDout;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .E_MDop(E_MDop), .E_rsValue(E_rsValue),
      .E_rtValue(E_rtValue), .E_MFsel(E_MFsel), .E_MDbusy(E_MDbusy),
      .E_HI(E_HI), .E_LO(E_LO), .E_MDout(E_MDout)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] hi; logic [31:0] lo; } res_t;
   res_t sb_q[$];

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = {hi, lo};
      case (op)
         3'd1: p = 64'(sa * sb);
         3'd2: p = {32'b0, a} * {32'b0, b};
         3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
         3'd4: if (b != 0) p = {a % b, a / b};
         default: ;
      endcase
      return p;
   endfunction

   task automatic mt(input logic [2:0] op, input logic [31:0] v);
      E_MDop = op; E_rsValue = v;
      tick();
      E_MDop = 3'd0;
      chk("mt_busy", {31'b0, E_MDbusy}, 32'd0);
      if (op == 3'd5) m_hi = v; else m_lo = v;
      chk("mt_hi", E_HI, m_hi);
      chk("mt_lo", E_LO, m_lo);
   endtask

   // Issue an op, optionally scramble inputs and present extra ops while busy.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ehi, input logic [31:0] elo, input int ncyc, input bit noisy);
      res_t r;
      int n;
      r.hi = ehi; r.lo = elo;
      sb_q.push_back(r);
      E_MDop = op; E_rsValue = rs; E_rtValue = rt;
      tick();
      E_MDop = 3'd0;
      chk({tag, "_busy_rise"}, {31'b0, E_MDbusy}, 32'd1);
      n = 0;
      while (E_MDbusy && n < 40) begin
         chk({tag, "_hold_hi"}, E_HI, m_hi);
         chk({tag, "_hold_lo"}, E_LO, m_lo);
         if (noisy) begin
            E_rsValue = $urandom; E_rtValue = $urandom;
            E_MDop = (n == 2) ? 3'd6 : 3'd1;
         end
         tick();
         n++;
      end
      E_MDop = 3'd0;
      chk({tag, "_cycles"}, 32'(n), 32'(ncyc));
      chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
      r = sb_q.pop_front();
      chk({tag, "_hi"}, E_HI, r.hi);
      chk({tag, "_lo"}, E_LO, r.lo);
      E_MFsel = 1'b0; #1;
      chk({tag, "_mdout_hi"}, E_MDout, r.hi);
      E_MFsel = 1'b1; #1;
      chk({tag, "_mdout_lo"}, E_MDout, r.lo);
      m_hi = r.hi; m_lo = r.lo;
      if (noisy) begin
         tick();
         chk({tag, "_no_restart"}, {31'b0, E_MDbusy}, 32'd0);
         chk({tag, "_stable_lo"}, E_LO, m_lo);
      end
   endtask

   task automatic run_model(input string tag, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      logic [63:0] p;
      p = model(op, rs, rt, m_hi, m_lo);
      run_op(tag, op, rs, rt, p[63:32], p[31:0], (op <= 3'd2) ? MC : DC, 1'b0);
   endtask

   initial begin
      reset = 1'b0; E_MDop = 3'd0; E_rsValue = '0; E_rtValue = '0; E_MFsel = 1'b0;
      #12;
      chk("rst_hi", E_HI, 32'd0);
      chk("rst_lo", E_LO, 32'd0);
      chk("rst_busy", {31'b0, E_MDbusy}, 32'd0);
      tick();
      reset = 1'b1;

      // First edge after release accepts MTHI, then MTLO back-to-back.
      mt(3'd5, 32'hDEADBEEF);
      mt(3'd6, 32'h12345678);
      E_MFsel = 1'b0; #1;
      chk("mt_mdout_hi", E_MDout, 32'hDEADBEEF);
      E_MFsel = 1'b1; #1;
      chk("mt_mdout_lo", E_MDout, 32'h12345678);

      run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC, 1'b0);
      run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MC, 1'b0);
      run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC, 1'b0);
      run_op("divu",  3'd4, 32'd7,        32'd2, 32'd1,        32'd3,        DC, 1'b0);
      run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DC, 1'b0);
      mt(3'd5, 32'h11);
      mt(3'd6, 32'h22);
      run_op("divu_z", 3'd4, 32'd5, 32'd0, 32'h11, 32'h22, DC, 1'b0);
      run_op("div_z",  3'd3, 32'hFFFFFFF0, 32'd0, 32'h11, 32'h22, DC, 1'b0);

      // Inputs scrambled and MTLO/MULT presented throughout the run.
      run_op("div_noisy", 3'd3, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, DC, 1'b1);

      for (int i = 0; i < 6; i++) begin
         logic [2:0] op;
         logic [31:0] a, b;
         op = 3'(1 + (i % 4));
         a = $urandom;
         b = (i == 5) ? 32'd0 : $urandom;
         if (i == 3) b = 32'd1 + $urandom_range(0, 255);
         run_model($sformatf("rnd%0d", i), op, a, b);
      end

      // Reset in the third busy cycle aborts the multiply.
      mt(3'd5, 32'hAAAA5555);
      mt(3'd6, 32'h5555AAAA);
      E_MDop = 3'd1; E_rsValue = 32'd3; E_rtValue = 32'd4;
      tick();
      E_MDop = 3'd0;
      chk("abort_busy_rise", {31'b0, E_MDbusy}, 32'd1);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("abort_hi", E_HI, 32'd0);
      chk("abort_lo", E_LO, 32'd0);
      chk("abort_busy", {31'b0, E_MDbusy}, 32'd0);
      m_hi = '0; m_lo = '0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("abort_after_busy", {31'b0, E_MDbusy}, 32'd0);
      chk("abort_after_hi", E_HI, 32'd0);
      chk("abort_after_lo", E_LO, 32'd0);
      run_op("mult_6x7", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42, MC, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
